// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution sequencer.
package instr_register_pkg;

  localparam int ADDR_W        = 5;
  localparam int OPERAND_W     = 32;
  localparam int RESULT_W      = 64;
  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic        [ADDR_W-1:0]    address_t;
  typedef logic signed [RESULT_W-1:0]  result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HOLD   = 3'd3,
    FINISH = 3'd4
  } exec_state_t;

  // Sign-extend a 32-bit operand to the full result width.
  function automatic result_t sext_operand(input operand_t op);
    return {{(RESULT_W-OPERAND_W){op[OPERAND_W-1]}}, op};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU: decodes one instruction and produces a signed result
// plus an error flag for divide/modulo by zero or an unknown opcode.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      result,
  output logic         error
);

  result_t a_ext_s;
  result_t b_ext_s;

  // Decode opcode and evaluate the operation on sign-extended operands.
  always_comb begin
    a_ext_s = sext_operand(instr.op_a);
    b_ext_s = sext_operand(instr.op_b);
    result  = 64'sd0;
    error   = 1'b0;
    case (instr.opc)
      ZERO:  result = 64'sd0;
      PASSA: result = a_ext_s;
      PASSB: result = b_ext_s;
      ADD:   result = a_ext_s + b_ext_s;
      SUB:   result = a_ext_s - b_ext_s;
      MULT:  result = a_ext_s * b_ext_s;
      DIV: begin
        if (b_ext_s == 64'sd0) begin
          result = 64'sd0;
          error  = 1'b1;
        end else begin
          result = a_ext_s / b_ext_s;
          error  = 1'b0;
        end
      end
      MOD: begin
        if (b_ext_s == 64'sd0) begin
          result = 64'sd0;
          error  = 1'b1;
        end else begin
          result = a_ext_s % b_ext_s;
          error  = 1'b0;
        end
      end
      default: begin
        result = 64'sd0;
        error  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks a range of instruction register slots, executes each instruction
// through instr_alu and presents every result on a valid/ready port.
module instr_exec_sequencer
  import instr_register_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     start_ptr,
  input  logic [5:0]   count,
  input  instruction_t instruction_word,
  output address_t     read_pointer,
  output logic         res_valid,
  input  logic         res_ready,
  output result_t      res_data,
  output opcode_t      res_opcode,
  output address_t     res_ptr,
  output logic         res_error,
  output logic         busy,
  output logic         done
);

  localparam logic [5:0] DEPTH_CNT = 6'(DEPTH);

  exec_state_t state_r;
  address_t    ptr_r;
  logic [5:0]  remaining_r;
  address_t    read_pointer_r;
  logic        res_valid_r;
  result_t     res_data_r;
  opcode_t     res_opcode_r;
  address_t    res_ptr_r;
  logic        res_error_r;
  logic        busy_r;
  logic        done_r;

  result_t     alu_result_s;
  logic        alu_error_s;

  // Slot index after p, wrapping at the end of the register file.
  function automatic address_t next_ptr(input address_t p);
    if (p == address_t'(DEPTH - 1)) begin
      return {ADDR_W{1'b0}};
    end else begin
      return p + 5'd1;
    end
  endfunction

  instr_alu u_alu (
    .instr  (instruction_word),
    .result (alu_result_s),
    .error  (alu_error_s)
  );

  // Run-control FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      ptr_r          <= {ADDR_W{1'b0}};
      remaining_r    <= 6'd0;
      read_pointer_r <= {ADDR_W{1'b0}};
      res_valid_r    <= 1'b0;
      res_data_r     <= 64'sd0;
      res_opcode_r   <= ZERO;
      res_ptr_r      <= {ADDR_W{1'b0}};
      res_error_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (count != 6'd0) begin
              ptr_r          <= start_ptr;
              read_pointer_r <= start_ptr;
              remaining_r    <= (count > DEPTH_CNT) ? DEPTH_CNT : count;
              state_r        <= FETCH;
            end else begin
              state_r <= FINISH;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        FETCH: begin
          read_pointer_r <= ptr_r;
          state_r        <= EXEC;
        end
        EXEC: begin
          res_data_r   <= alu_result_s;
          res_opcode_r <= instruction_word.opc;
          res_ptr_r    <= ptr_r;
          res_error_r  <= alu_error_s;
          res_valid_r  <= 1'b1;
          state_r      <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            remaining_r <= remaining_r - 6'd1;
            ptr_r       <= next_ptr(ptr_r);
            if (remaining_r == 6'd1) begin
              state_r <= FINISH;
            end else begin
              read_pointer_r <= next_ptr(ptr_r);
              state_r        <= FETCH;
            end
          end else begin
            res_valid_r <= 1'b1;
          end
        end
        FINISH: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign read_pointer = read_pointer_r;
  assign res_valid    = res_valid_r;
  assign res_data     = res_data_r;
  assign res_opcode   = res_opcode_r;
  assign res_ptr      = res_ptr_r;
  assign res_error    = res_error_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule
